// File: rtl/packet_stream_reader.sv
// Streams completed packets out of a slot buffer, one byte per cycle with
// valid/ready/last, prefetching the next word while the current one drains.
module packet_stream_reader #(
   parameter int data_width_p = 64,
   parameter int els_p        = 2048,
   localparam int bytes_lp             = data_width_p / 8,
   localparam int addr_width_lp        = $clog2(els_p),
   localparam int packet_size_width_lp = $clog2(els_p + 1)
) (
   input  logic                            clk_i,
   input  logic                            reset_i,
   input  logic                            packet_avail_i,
   input  logic [packet_size_width_lp-1:0] packet_rsize_i,
   output logic                            packet_ack_o,
   output logic                            packet_rvalid_o,
   output logic [addr_width_lp-1:0]        packet_raddr_o,
   input  logic [data_width_p-1:0]         packet_rdata_i,
   output logic                            tx_v_o,
   output logic [7:0]                      tx_data_o,
   output logic                            tx_last_o,
   input  logic                            tx_ready_i
);

   localparam int idx_width_lp = $clog2(bytes_lp);
   localparam logic [idx_width_lp-1:0]         last_idx_lp = idx_width_lp'(bytes_lp - 1);
   localparam logic [packet_size_width_lp-1:0] bytes_w_lp  = packet_size_width_lp'(bytes_lp);
   localparam logic [packet_size_width_lp-1:0] one_lp      = packet_size_width_lp'(1);

   typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_e;

   state_e                            state_r, state_n;
   logic [packet_size_width_lp-1:0]   size_r, sent_r, rd_addr_r;
   logic [idx_width_lp-1:0]           byte_idx_r;
   logic [bytes_lp-1:0][7:0]          cur_r, nxt_r;
   logic                              nxt_v_r, rd_pend_r, wait_r;
   logic                              hs, wrap;

   always_comb begin
      state_n         = state_r;
      packet_ack_o    = 1'b0;
      packet_rvalid_o = 1'b0;
      packet_raddr_o  = '0;
      tx_v_o          = 1'b0;
      tx_data_o       = 8'h00;
      tx_last_o       = 1'b0;
      case (state_r)
         IDLE: begin
            // reset gating keeps the read strobe quiet while the slot is still held
            if (packet_avail_i && !reset_i) begin
               if (packet_rsize_i != '0) begin
                  state_n         = LOAD;
                  packet_rvalid_o = 1'b1;
               end else begin
                  state_n = DONE;
               end
            end
         end
         LOAD: state_n = STREAM;
         STREAM: begin
            tx_v_o    = ~wait_r;
            tx_data_o = cur_r[byte_idx_r];
            tx_last_o = tx_v_o & (sent_r == size_r - one_lp);
            if ((rd_addr_r < size_r) && !rd_pend_r && !nxt_v_r) begin
               packet_rvalid_o = 1'b1;
               packet_raddr_o  = rd_addr_r[addr_width_lp-1:0];
            end
            if (tx_last_o && tx_ready_i)
               state_n = DONE;
         end
         DONE: begin
            packet_ack_o = 1'b1;
            state_n      = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign hs   = tx_v_o & tx_ready_i;
   assign wrap = hs & ~tx_last_o & (byte_idx_r == last_idx_lp);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r    <= IDLE;
         size_r     <= '0;
         sent_r     <= '0;
         rd_addr_r  <= '0;
         byte_idx_r <= '0;
         cur_r      <= '0;
         nxt_r      <= '0;
         nxt_v_r    <= 1'b0;
         rd_pend_r  <= 1'b0;
         wait_r     <= 1'b0;
      end else begin
         state_r   <= state_n;
         rd_pend_r <= (state_r == STREAM) & packet_rvalid_o;
         case (state_r)
            IDLE: begin
               if (state_n == LOAD) begin
                  size_r    <= packet_rsize_i;
                  rd_addr_r <= bytes_w_lp;
               end
            end
            LOAD: begin
               cur_r      <= packet_rdata_i;
               byte_idx_r <= '0;
               sent_r     <= '0;
               nxt_v_r    <= 1'b0;
               wait_r     <= 1'b0;
            end
            STREAM: begin
               if (packet_rvalid_o)
                  rd_addr_r <= rd_addr_r + bytes_w_lp;
               // a returning word lands in cur_r directly when the stream is starved
               if (rd_pend_r && !wrap) begin
                  if (wait_r) begin
                     cur_r  <= packet_rdata_i;
                     wait_r <= 1'b0;
                  end else begin
                     nxt_r   <= packet_rdata_i;
                     nxt_v_r <= 1'b1;
                  end
               end
               if (hs) begin
                  sent_r <= sent_r + one_lp;
                  if (wrap) begin
                     byte_idx_r <= '0;
                     nxt_v_r    <= 1'b0;
                     if (nxt_v_r)        cur_r  <= nxt_r;
                     else if (rd_pend_r) cur_r  <= packet_rdata_i;
                     else                wait_r <= 1'b1;
                  end else if (!tx_last_o) begin
                     byte_idx_r <= byte_idx_r + idx_width_lp'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assert property (@(posedge clk_i) disable iff (reset_i)
      (state_r == IDLE && state_n == LOAD) |-> (packet_rsize_i <= packet_size_width_lp'(els_p)));
   assert property (@(posedge clk_i) disable iff (reset_i)
      packet_ack_o |-> packet_avail_i);

endmodule

// File: tb/tb_packet_stream_reader.sv
// Directed bench for packet_stream_reader: 64-bit and 32-bit instances,
// scoreboard of expected {last, byte} beats plus timing and read-address checks.
module tb_packet_stream_reader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        avail, ack, rvalid, tv, tl, tr;
   logic [11:0] rsize;
   logic [10:0] raddr;
   logic [63:0] rdata = '0;
   logic [7:0]  td;

   logic        avail32, ack32, rvalid32, tv32, tl32, tr32;
   logic [11:0] rsize32;
   logic [10:0] raddr32;
   logic [31:0] rdata32 = '0;
   logic [7:0]  td32;

   logic [7:0]  mem64 [2048];
   logic [7:0]  mem32 [2048];

   int cyc = 0, checks = 0, errors = 0;
   logic [8:0]  exp_q[$], exp32_q[$];
   logic [10:0] rd_q[$];

   packet_stream_reader #(.data_width_p(64), .els_p(2048)) u_dut (
      .clk_i(clk), .reset_i(reset), .packet_avail_i(avail), .packet_rsize_i(rsize),
      .packet_ack_o(ack), .packet_rvalid_o(rvalid), .packet_raddr_o(raddr),
      .packet_rdata_i(rdata), .tx_v_o(tv), .tx_data_o(td), .tx_last_o(tl),
      .tx_ready_i(tr));

   packet_stream_reader #(.data_width_p(32), .els_p(2048)) u_dut32 (
      .clk_i(clk), .reset_i(reset), .packet_avail_i(avail32), .packet_rsize_i(rsize32),
      .packet_ack_o(ack32), .packet_rvalid_o(rvalid32), .packet_raddr_o(raddr32),
      .packet_rdata_i(rdata32), .tx_v_o(tv32), .tx_data_o(td32), .tx_last_o(tl32),
      .tx_ready_i(tr32));

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rvalid)
         for (int i = 0; i < 8; i++) rdata[i*8 +: 8] <= mem64[int'(raddr) + i];
      if (rvalid32)
         for (int i = 0; i < 4; i++) rdata32[i*8 +: 8] <= mem32[int'(raddr32) + i];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // 64-bit monitor: scoreboard pop, stall stability, reads, acks
   logic       prev_v = 1'b0, stall_prev = 1'b0, prev_l = 1'b0;
   logic [7:0] prev_d = 8'h00;
   int first_v_cyc = 0, last_hs_cyc = 0, ack_cyc = 0, ack_cnt = 0;
   always @(negedge clk) begin
      if (stall_prev) chk("stall_hold", 32'({tv, tl, td}), 32'({1'b1, prev_l, prev_d}));
      if (tv && !prev_v) first_v_cyc = cyc;
      if (tv && tr) begin
         chk("beat_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            logic [8:0] e;
            e = exp_q.pop_front();
            chk("beat", 32'({tl, td}), 32'(e));
         end
         if (tl) last_hs_cyc = cyc;
      end
      if (rvalid) rd_q.push_back(raddr);
      if (ack) begin
         ack_cnt++;
         ack_cyc = cyc;
         chk("ack_avail", 32'(avail), 1);
      end
      prev_v = tv; stall_prev = tv & ~tr; prev_l = tl; prev_d = td;
   end

   int first32 = -1, last32 = 0, ack32_cnt = 0, rd32_cnt = 0;
   logic [10:0] rd32_last = '0, rd32_max = '0;
   always @(negedge clk) begin
      if (tv32 && first32 < 0) first32 = cyc;
      if (tv32 && tr32) begin
         chk("beat32_expected", 32'(exp32_q.size() != 0), 1);
         if (exp32_q.size() != 0) begin
            logic [8:0] e;
            e = exp32_q.pop_front();
            if ({tl32, td32} !== e) chk("beat32", 32'({tl32, td32}), 32'(e));
         end
         if (tl32) last32 = cyc;
      end
      if (rvalid32) begin
         rd32_cnt++;
         rd32_last = raddr32;
         if (raddr32 > rd32_max) rd32_max = raddr32;
      end
      if (ack32) ack32_cnt++;
   end

   int rcnt = 0;
   bit ready_mode = 1'b0;
   task automatic tick();
      @(posedge clk); #1;
      rcnt++;
      tr = ready_mode ? ((rcnt % 4 == 0) || (rcnt % 4 == 3)) : 1'b1;
   endtask

   int av_cyc = 0;
   task automatic load_pkt(input logic [7:0] base, input int size);
      for (int i = 0; i < size; i++) begin
         logic [7:0] b;
         b = base + 8'(i);
         mem64[i] = b;
         exp_q.push_back({i == size - 1, b});
      end
      rsize  = 12'(size);
      avail  = 1'b1;
      av_cyc = cyc;
   endtask

   task automatic wait_ack(input bit sel, input int budget);
      bit found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (sel ? ack32 : ack) found = 1'b1;
         tick();
      end
      chk(sel ? "ack32_timeout" : "ack_timeout", 32'(found), 1);
      if (sel) avail32 = 1'b0; else avail = 1'b0;
   endtask

   initial begin
      int l1, ack_before, rel, av32;
      reset = 1'b1; avail = 1'b0; rsize = '0; tr = 1'b1;
      avail32 = 1'b0; rsize32 = '0; tr32 = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      chk("reset_outs64", 32'({ack, rvalid, raddr, tv, td, tl}), 0);
      chk("reset_outs32", 32'({ack32, rvalid32, raddr32, tv32, td32, tl32}), 0);
      tick(); reset = 1'b0; tick();

      // 13 bytes, ready held high
      rd_q.delete();
      load_pkt(8'h00, 13);
      wait_ack(0, 200);
      chk("t1_first_lat", first_v_cyc, av_cyc + 2);
      chk("t1_ack_lat", ack_cyc, last_hs_cyc + 1);
      chk("t1_drained", exp_q.size(), 0);
      chk("t1_nreads", rd_q.size(), 2);
      if (rd_q.size() == 2) begin
         chk("t1_raddr0", 32'(rd_q[0]), 0);
         chk("t1_raddr1", 32'(rd_q[1]), 8);
      end

      // same packet with ready toggling 1,0,0,1
      ready_mode = 1'b1;
      rd_q.delete();
      load_pkt(8'h00, 13);
      wait_ack(0, 200);
      ready_mode = 1'b0; tr = 1'b1;
      chk("t2_drained", exp_q.size(), 0);
      chk("t2_nreads", rd_q.size(), 2);
      chk("t2_ack_lat", ack_cyc, last_hs_cyc + 1);

      // zero-size packet
      rd_q.delete();
      load_pkt(8'h00, 0);
      wait_ack(0, 20);
      chk("t3_ack_lat", ack_cyc, av_cyc + 1);
      chk("t3_nreads", rd_q.size(), 0);

      // back-to-back 8-byte packets
      load_pkt(8'h10, 8);
      wait_ack(0, 100);
      l1 = last_hs_cyc;
      load_pkt(8'hA0, 8);
      wait_ack(0, 100);
      chk("t4_gap", first_v_cyc, l1 + 4);
      chk("t4_drained", exp_q.size(), 0);

      // reset on beat 5 of a 20-byte packet, then replay
      load_pkt(8'h30, 20);
      repeat (6) tick();
      reset = 1'b1;
      ack_before = ack_cnt;
      tick();
      @(negedge clk);
      chk("t5_rst_outs", 32'({ack, rvalid, raddr, tv, td, tl}), 0);
      chk("t5_beats_before_rst", exp_q.size(), 15);
      exp_q.delete();
      rd_q.delete();
      load_pkt(8'h30, 20);
      tick();
      reset = 1'b0;
      rel = cyc;
      wait_ack(0, 200);
      chk("t5_replay_lat", first_v_cyc, rel + 2);
      chk("t5_one_ack", ack_cnt, ack_before + 1);
      chk("t5_drained", exp_q.size(), 0);
      chk("t5_nreads", rd_q.size(), 3);

      // 32-bit, full 2048-byte slot
      for (int i = 0; i < 2048; i++) begin
         mem32[i] = 8'(i);
         exp32_q.push_back({i == 2047, 8'(i)});
      end
      rsize32 = 12'd2048;
      avail32 = 1'b1;
      av32 = cyc;
      wait_ack(1, 2300);
      chk("t6_drained", exp32_q.size(), 0);
      chk("t6_first_lat", first32, av32 + 2);
      chk("t6_no_bubbles", last32 - first32, 2047);
      chk("t6_nreads", rd32_cnt, 512);
      chk("t6_last_raddr", 32'(rd32_last), 2044);
      chk("t6_max_raddr", 32'(rd32_max), 2044);
      chk("t6_acks", ack32_cnt, 1);

      chk("total_acks64", ack_cnt, 6);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
